// File: rtl/serial_addsub_if.sv
// Start/done handshake and operand/result bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, sub,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// Optional macro SERIAL_ADDSUB_SAT_EN saturates the result on signed overflow.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// RUN    | shifting one bit per cycle through the full adder
// DONE   | one-cycle done pulse; a new start here is accepted
module serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sum_bit;
  logic             carry_nxt;
  logic             last_bit;
  logic             ovf_raw;
  logic             accept;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] res_final;

  assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign acc_shift = {sum_bit, acc_q[WIDTH-1:1]};
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // While the MSB is being processed, carry_q already is the carry into the MSB.
  assign ovf_raw   = carry_q ^ carry_nxt;
  assign accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef SERIAL_ADDSUB_SAT_EN
  // opa_q[0] holds the operand A sign bit during the final bit cycle.
  assign res_final = !ovf_raw  ? acc_shift :
                     opa_q[0]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                 {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_final = acc_shift;
`endif

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        acc_d   = acc_shift;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d  = S_DONE;
          result_d = res_final;
          cout_d   = carry_nxt;
          ovf_d    = ovf_raw;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor. Processes one bit per clock, LSB first, using a single full-adder cell and a carry/borrow flop.
- Serves as the low-area subtraction path for exponent differencing and mantissa alignment in the floating-point datapath.
- Operands enter through a start/done handshake. The result is held until the next accepted start.

Parameters:
- WIDTH, 16, operand and result width in bits (legal range 2..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when accepting.
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- sub  input  1  captured on an accepted start; 1 = A-B, 0 = A+B.
- busy  output  1  high while the operation is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- result  output  WIDTH  sum or difference.
- cout  output  1  carry out of the MSB. For subtraction, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - busy, done, result, cout and overflow all 0.
  - Internal shift registers, bit counter and carry flop all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 is accepted:
    - latch A to opA;
    - latch (sub ? ~B : B) to opB;
    - carry = sub;
    - count = 0;
    - go to RUN.
- RUN:
  - busy = 1.
  - Each cycle:
    - s = opA[0] ^ opB[0] ^ carry;
    - carry_next = majority(opA[0], opB[0], carry);
    - shift s into the accumulator MSB (shift right);
    - shift opA and opB right by 1;
    - count++.
  - When count == WIDTH-2 (bit WIDTH-1 is about to be processed), register the current carry as the carry into the MSB.
  - On the cycle processing bit WIDTH-1 (count == WIDTH-1), go to DONE.
  - start is ignored; inputs a, b and sub may change freely.
- DONE (exactly one cycle):
  - done = 1, busy = 0.
  - result = accumulator.
  - cout = final carry.
  - overflow = carry into MSB ^ final carry.
  - start = 1 in DONE is accepted (same capture as IDLE), giving back-to-back operation. Otherwise go to IDLE.
- Latency: start accepted at edge N gives done = 1 in the cycle after edge N+WIDTH. That is WIDTH RUN cycles plus 1 DONE cycle.
- Maximum throughput: one operation per WIDTH+1 cycles.
- Output hold:
  - result, cout and overflow change only on entry to DONE.
  - They hold through IDLE and the next RUN, until the next DONE.
  - busy is never high in the same cycle as done.
- Boundary conditions:
  - B = 0 with sub = 1: result = A, cout = 1.
  - A = B with sub = 1: result = 0, cout = 1, overflow = 0.
  - Most negative minus 1: overflow = 1.
- Reset during RUN: operation abandoned. No done pulse is produced and outputs return to 0.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- When defined: on signed overflow, result saturates instead of wrapping.
  - Positive overflow (operands effectively positive) gives {0, {WIDTH-1{1}}}.
  - Negative overflow gives {1, {WIDTH-1{0}}}.
  - The saturation sign is taken from the effective-operand MSBs (opA MSB, which equals opB MSB when overflow occurs).
  - overflow and cout still report the raw flags.
  - Adds one WIDTH-wide mux before the result register. Latency is unchanged.
- When undefined: result is always the raw wrapped sum.

Test Plan (WIDTH = 8):
- 8'h05 - 8'h03 (sub = 1), start at edge 0:
  - done only in the cycle after edge 8;
  - result = 8'h02, cout = 1, overflow = 0;
  - busy high for exactly 8 cycles.
- 8'h03 - 8'h05: result = 8'hFE, cout = 0, overflow = 0.
- 8'h7F + 8'h01 (sub = 0): cout = 0, overflow = 1.
  - Result = 8'h80 without the macro; 8'h7F with SERIAL_ADDSUB_SAT_EN.
- 8'h80 - 8'h01: cout = 1, overflow = 1.
  - Result = 8'h7F without the macro; 8'h80 with the macro.
- Start pulse plus changed a/b/sub during RUN:
  - ignored;
  - original result delivered;
  - a second start asserted during the DONE cycle is accepted, and its done follows 9 cycles later.
- reset asserted at RUN cycle 4 of 8'hFF + 8'h01:
  - busy, done, result, cout and overflow drop to 0 immediately;
  - no done pulse;
  - the next start completes normally (result 8'h00, cout 1, overflow 0).
